// File: rtl/nway_cache.sv
`timescale 1ns/1ps
// N-way set-associative write-back, write-allocate cache with tree pseudo-LRU replacement.
// CPU side is a 32-bit word port; the memory side moves whole lines.
module nway_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_ways   = 2,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * (2 ** s_offset)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              pmem_error
);

  localparam int WAYS  = 2 ** s_ways;
  localparam int SETS  = 2 ** s_index;
  localparam int PBITS = WAYS - 1;
  localparam int WSEL  = s_offset - 2;

  typedef enum logic [1:0] {
    CHECK_TAG  = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_e;

  // Tree nodes are stored heap-style (children of node n are 2n+1, 2n+2); a 0 bit points left.
  function automatic logic [s_ways-1:0] plru_victim(input logic [PBITS-1:0] bits);
    logic [s_ways-1:0] idx;
    logic [s_ways-1:0] way;
    idx = '0;
    way = '0;
    for (int l = 0; l < s_ways; l++) begin
      way = s_ways'({way, bits[idx]});
      idx = s_ways'({idx, 1'b1} + {{s_ways{1'b0}}, bits[idx]});
    end
    return way;
  endfunction

  function automatic logic [PBITS-1:0] plru_touch(input logic [PBITS-1:0] bits,
                                                  input logic [s_ways-1:0] way);
    logic [PBITS-1:0] nb;
    logic [s_ways-1:0] idx;
    logic              dir;
    nb  = bits;
    idx = '0;
    for (int l = 0; l < s_ways; l++) begin
      dir     = way[s_ways-1-l];
      nb[idx] = ~dir;
      idx     = s_ways'({idx, 1'b1} + {{s_ways{1'b0}}, dir});
    end
    return nb;
  endfunction

  function automatic logic [s_line-1:0] merge_line(input logic [s_line-1:0] line,
                                                   input logic [WSEL-1:0]   wsel,
                                                   input logic [31:0]       wdata,
                                                   input logic [3:0]        be);
    logic [s_line-1:0] res;
    logic [31:0]       word;
    res  = line;
    word = line[{wsel, 5'b00000} +: 32];
    for (int b = 0; b < 4; b++) begin
      word[8*b +: 8] = be[b] ? wdata[8*b +: 8] : word[8*b +: 8];
    end
    res[{wsel, 5'b00000} +: 32] = word;
    return res;
  endfunction

  logic [s_line-1:0] data_q  [SETS][WAYS];
  logic [s_tag-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [PBITS-1:0]  plru_q  [SETS];

  state_e            state_q, state_d;
  logic [s_ways-1:0] victim_q, victim_d;

  logic [s_tag-1:0]   tag_s;
  logic [s_index-1:0] index_s;
  logic [WSEL-1:0]    word_s;
  logic               req_s;
  logic               hit_s;
  logic [s_ways-1:0]  hit_way_s;
  logic               has_inv_s;
  logic [s_ways-1:0]  inv_way_s;
  logic [s_ways-1:0]  victim_sel_s;
  logic               victim_dirty_s;
  logic [s_line-1:0]  hit_line_s;
  logic               unused_s;

  assign tag_s    = mem_addr[31 -: s_tag];
  assign index_s  = mem_addr[s_offset +: s_index];
  assign word_s   = mem_addr[2 +: WSEL];
  assign req_s    = mem_read | mem_write;
  assign unused_s = ^mem_addr[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[index_s][w] && (tag_q[index_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = s_ways'(w);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Victim choice: lowest-numbered invalid way wins, otherwise the PLRU way.
  always_comb begin
    has_inv_s = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[index_s][w]) begin
        has_inv_s = 1'b1;
        inv_way_s = s_ways'(w);
      end else begin
        has_inv_s = has_inv_s;
      end
    end
    if (has_inv_s) begin
      victim_sel_s = inv_way_s;
    end else begin
      victim_sel_s = plru_victim(plru_q[index_s]);
    end
    victim_dirty_s = valid_q[index_s][victim_sel_s] & dirty_q[index_s][victim_sel_s];
  end

  // State and victim registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CHECK_TAG;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      CHECK_TAG: begin
        if (req_s && !hit_s) begin
          victim_d = victim_sel_s;
          state_d  = victim_dirty_s ? WRITE_BACK : ALLOCATE;
        end else begin
          state_d  = CHECK_TAG;
        end
      end
      WRITE_BACK: begin
        if (pmem_resp) begin
          state_d = ALLOCATE;
        end else begin
          state_d = WRITE_BACK;
        end
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          state_d = CHECK_TAG;
        end else begin
          state_d = ALLOCATE;
        end
      end
      default: state_d = CHECK_TAG;
    endcase
  end

  // Output decode; strobes derive from the async-reset state so they drop with reset_n.
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = 32'd0;
    case (state_q)
      CHECK_TAG: mem_resp = req_s & hit_s;
      WRITE_BACK: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_q[index_s][victim_q], index_s, {s_offset{1'b0}}};
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_addr = {mem_addr[31:s_offset], {s_offset{1'b0}}};
      end
      default: mem_resp = 1'b0;
    endcase
  end

  assign hit_line_s = data_q[index_s][hit_way_s];
  assign mem_rdata  = hit_line_s[{word_s, 5'b00000} +: 32];
  assign pmem_wdata = data_q[index_s][victim_q];

  // Metadata: valid, dirty and PLRU bits are cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        CHECK_TAG: begin
          if (req_s && hit_s) begin
            plru_q[index_s] <= plru_touch(plru_q[index_s], hit_way_s);
            if (mem_write) begin
              dirty_q[index_s][hit_way_s] <= 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          if (pmem_resp) begin
            dirty_q[index_s][victim_q] <= 1'b0;
          end
        end
        ALLOCATE: begin
          if (pmem_resp && pmem_error) begin
            valid_q[index_s][victim_q] <= 1'b0;
          end else if (pmem_resp) begin
            valid_q[index_s][victim_q] <= 1'b1;
            dirty_q[index_s][victim_q] <= 1'b0;
            plru_q[index_s]            <= plru_touch(plru_q[index_s], victim_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; validity is guarded by valid_q.
  always_ff @(posedge clk) begin
    if ((state_q == CHECK_TAG) && mem_write && hit_s) begin
      data_q[index_s][hit_way_s] <= merge_line(hit_line_s, word_s, mem_wdata, mem_byte_enable);
    end else if ((state_q == ALLOCATE) && pmem_resp && !pmem_error) begin
      data_q[index_s][victim_q] <= pmem_rdata;
      tag_q[index_s][victim_q]  <= tag_s;
    end
  end

endmodule

// File: tb/tb_nway_cache.sv
`timescale 1ns/1ps
// Bench for nway_cache: flat-memory scoreboard for read data plus a recency-based cache model
// predicting hits, victims, write-backs and miss latency.
module tb_nway_cache;

  localparam int SETS = 8;
  localparam int WAYS = 4;

  logic         clk, reset_n;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata, pmem_addr;
  logic         mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp, pmem_error;
  logic [3:0]   mem_byte_enable;
  logic [255:0] pmem_wdata, pmem_rdata;

  nway_cache #(.s_offset(5), .s_index(3), .s_ways(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .pmem_error(pmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; int cyc; } ev_t;
  typedef struct { bit chk; logic [31:0] data; logic [31:0] addr; } sb_t;

  ev_t ev_q[$];
  sb_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  err_pending = 1'b0;
  bit  resp_hold = 1'b0;

  logic [31:0]  ref_mem [logic [31:0]];
  logic [255:0] bk_mem  [logic [31:0]];

  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [23:0] m_tag   [SETS][WAYS];
  int unsigned m_last  [SETS][WAYS];
  int unsigned m_time = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (req addr %h): got %h expected %h", name, mem_addr, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_word(k);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_rd(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [255:0] bk_load(input logic [31:0] la);
    logic [255:0] l;
    if (bk_mem.exists(la)) return bk_mem[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  // Tree PLRU seen as recency: at each split descend into the half whose newest access is older.
  function automatic int plru_pick(input int s);
    int lo, hi, mid;
    int unsigned ml, mr;
    lo = 0; hi = WAYS;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2; ml = 0; mr = 0;
      for (int w = lo; w < mid; w++) if (m_last[s][w] > ml) ml = m_last[s][w];
      for (int w = mid; w < hi; w++) if (m_last[s][w] > mr) mr = m_last[s][w];
      if (ml <= mr) hi = mid; else lo = mid;
    end
    return lo;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_last[s][w] = 0; m_tag[s][w] = '0;
      end
  endtask

  // Memory responder: random latency, write-back data checked against the flat reference.
  initial begin : responder
    int wait_cnt, lat;
    ev_t ev;
    pmem_resp = 1'b0; pmem_error = 1'b0; pmem_rdata = '0; wait_cnt = 0; lat = 1;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0; pmem_error = 1'b0;
      if (!(pmem_read || pmem_write) || resp_hold) wait_cnt = 0;
      else if (wait_cnt < lat) wait_cnt++;
      else begin
        wait_cnt = 0; lat = $urandom_range(0, 3);
        ev.wr = pmem_write; ev.addr = pmem_addr; ev.cyc = int'($time / 10);
        if (pmem_write) begin
          checks++;
          if (pmem_wdata !== ref_line(pmem_addr)) begin
            errors++;
            $display("FAIL wb_data addr %h: got %h expected %h", pmem_addr, pmem_wdata, ref_line(pmem_addr));
          end
          bk_mem[pmem_addr] = pmem_wdata;
        end else begin
          pmem_rdata = bk_load(pmem_addr);
          if (err_pending) begin pmem_error = 1'b1; err_pending = 1'b0; end
        end
        pmem_resp = 1'b1;
        ev_q.push_back(ev);
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and checks strobe exclusivity.
  sb_t mon_e;
  always begin
    @(negedge clk);
    #2;
    if (pmem_read && pmem_write) begin
      checks++; errors++;
      $display("FAIL strobe_overlap: got read=1 write=1 expected at most one");
    end
    if (mem_resp === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got mem_resp=1 expected no outstanding request");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) check32("rdata", mem_rdata, mon_e.data);
      end
    end
  end

  // One CPU request: predict, issue at a negedge, wait for completion, check memory traffic.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit err_req);
    int set, way, cycles, resp_cyc;
    bit hit, inj;
    logic [23:0] tag;
    logic [31:0] old_w, new_w, line_a;
    bit exp_w[$];
    logic [31:0] exp_a[$];
    sb_t e;
    set = int'(addr[7:5]); tag = addr[31:8]; line_a = {addr[31:5], 5'b00000};
    hit = 1'b0; way = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1'b1; way = w; end
    inj = err_req && !hit;
    if (!hit) begin
      way = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) way = w;
      if (way < 0) way = plru_pick(set);
      if (m_valid[set][way] && m_dirty[set][way]) begin
        exp_w.push_back(1'b1); exp_a.push_back({m_tag[set][way], addr[7:5], 5'b00000});
      end
      exp_w.push_back(1'b0); exp_a.push_back(line_a);
      if (inj) begin exp_w.push_back(1'b0); exp_a.push_back(line_a); end
      m_valid[set][way] = 1'b1; m_tag[set][way] = tag; m_dirty[set][way] = 1'b0;
      m_time++; m_last[set][way] = m_time;
    end
    m_time++; m_last[set][way] = m_time;
    if (wr) m_dirty[set][way] = 1'b1;

    old_w = ref_rd(addr);
    e.chk = !wr; e.data = old_w; e.addr = addr;
    sb_q.push_back(e);
    if (wr) begin
      new_w = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[{addr[31:2], 2'b00}] = new_w;
    end
    err_pending = inj;

    mem_addr = addr; mem_read = !wr; mem_write = wr; mem_wdata = wd; mem_byte_enable = be;
    #1;
    cycles = 0;
    while (mem_resp !== 1'b1 && cycles < 300) begin
      @(negedge clk); #1; cycles++;
    end
    resp_cyc = int'($time / 10);
    if (cycles >= 300) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr %h: got no mem_resp expected one within 300 cycles", addr);
    end
    check32("ev_count", 32'(ev_q.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < ev_q.size(); i++) begin
      check32("ev_kind", {31'd0, ev_q[i].wr}, {31'd0, exp_w[i]});
      check32("ev_addr", ev_q[i].addr, exp_a[i]);
    end
    if (hit) check32("hit_latency", 32'(cycles), 32'd0);
    else if (ev_q.size() > 0) check32("miss_latency", 32'(resp_cyc), 32'(ev_q[ev_q.size()-1].cyc + 1));
    ev_q.delete();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin : stimulus
    int cycles;
    logic [31:0] ra;
    mem_addr = 32'd0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = 32'd0;
    mem_byte_enable = 4'd0; reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check32("reset_mem_resp", {31'd0, mem_resp}, 32'd0);
    check32("reset_pmem_read", {31'd0, pmem_read}, 32'd0);
    check32("reset_pmem_write", {31'd0, pmem_write}, 32'd0);
    check32("reset_pmem_addr", pmem_addr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset while a fill is outstanding: strobe must fall without a clock edge.
    resp_hold = 1'b1;
    mem_addr = 32'h0000_0040; mem_read = 1'b1;
    cycles = 0;
    #1;
    while (pmem_read !== 1'b1 && cycles < 20) begin @(negedge clk); #1; cycles++; end
    check32("t5_alloc_read", {31'd0, pmem_read}, 32'd1);
    check32("t5_alloc_addr", pmem_addr, 32'h0000_0040);
    #1 reset_n = 1'b0;
    #1;
    check32("t5_async_drop", {31'd0, pmem_read}, 32'd0);
    check32("t5_async_addr", pmem_addr, 32'd0);
    mem_read = 1'b0;
    ev_q.delete(); sb_q.delete(); err_pending = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1; resp_hold = 1'b0;
    @(negedge clk);

    // Fill of 0x40 after reset (must miss again), then partial write and readback.
    do_req(1'b0, 32'h0000_0040, 32'd0, 4'b0000, 1'b0);
    do_req(1'b1, 32'h0000_0044, 32'h1122_3344, 4'b0011, 1'b0);
    do_req(1'b0, 32'h0000_0044, 32'd0, 4'b0000, 1'b0);

    // Set 0: four fills, touch ways 2,0,1, then a miss must evict way 3 (tag 4).
    for (int t = 1; t <= 4; t++) do_req(1'b0, 32'(t) << 8, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0300, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0104, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0208, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0500, 32'd0, 4'b0000, 1'b0);
    for (int t = 1; t <= 3; t++) do_req(1'b0, (32'(t) << 8) | 32'h0000_000C, 32'd0, 4'b0000, 1'b0);

    // Set 2: fill remaining ways, next miss evicts the dirty 0x40 line first.
    do_req(1'b0, 32'h0000_0140, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0240, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0340, 32'd0, 4'b0000, 1'b0);
    do_req(1'b0, 32'h0000_0440, 32'd0, 4'b0000, 1'b0);

    // Errored fill is retried before completing.
    do_req(1'b0, 32'h0000_0600, 32'd0, 4'b0000, 1'b1);
    do_req(1'b0, 32'h0000_0604, 32'd0, 4'b0000, 1'b0);

    // Random traffic over a small footprint so hits, evictions and write-backs all occur.
    for (int i = 0; i < 400; i++) begin
      ra = {21'd0, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 2'b00};
      do_req(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(negedge clk);
    check32("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
